axi_stream_burst_writer: RTL and testbench
==========================================

AXI_STREAM_BURST_WRITER -- requirements
Module: axi_stream_burst_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI write data and stream width in bits; SHALL be 8, 16, 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 16: AXI address width in bits.
REQ-003 Parameter LEN_WIDTH, default 16: width of the total-beat-count input.
REQ-004 Parameter MAX_BURST, default 16: maximum beats per AXI burst; SHALL be in the range 1..256.
REQ-005 clk  in  1  the single clock; all logic is on posedge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  one-cycle request to begin a transfer.
REQ-008 base_addr  in  ADDR_WIDTH  byte address of the first beat.
REQ-009 num_beats  in  LEN_WIDTH  total number of beats to write.
REQ-010 s_data  in  DATA_WIDTH  input stream data.
REQ-011 s_valid  in  1  input stream data valid.
REQ-012 s_ready  out  1  input stream ready.
REQ-013 axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_WIDTH/8/3/2/1  write address channel.
REQ-014 axi_awready  in  1  write address accept.
REQ-015 axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
REQ-016 axi_wready  in  1  write data accept.
REQ-017 axi_bresp/bvalid  in  2/1; axi_bready  out  1  write response channel.
REQ-018 busy  out  1  high from start acceptance until done.
REQ-019 valid  out  1  one-cycle completion pulse.
REQ-020 error  out  1  sticky flag for a non-OKAY bresp in the current transfer.

Function
REQ-021 The FSM SHALL have the states IDLE, ADDR, DATA, RESP and FIN.
REQ-022 IDLE: a start SHALL latch base_addr and num_beats, clear error and set busy. The next state SHALL be ADDR, or FIN when num_beats==0.
REQ-023 Burst size: beats = min(remaining, MAX_BURST); awlen = beats-1; awsize = log2(DATA_WIDTH/8); awburst = 2'b01 (INCR); awaddr = current address.
REQ-024 ADDR: awvalid SHALL be high, with all aw fields stable, until the cycle awready is high; the FSM SHALL then move to DATA.
REQ-025 DATA: wvalid = s_valid and s_ready = wready, purely combinational, with no extra buffering. wdata = s_data and wstrb = all ones.
REQ-026 DATA: a beat SHALL transfer on a cycle where s_valid && wready. wlast SHALL be high exactly on the last beat of each burst.
REQ-027 After the wlast beat transfers, the FSM SHALL move to RESP.
REQ-028 RESP: bready SHALL be high.
REQ-029 On bvalid in RESP:
  - error SHALL be set if bresp != 2'b00;
  - remaining -= beats;
  - address += beats*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH;
  - the next state SHALL be ADDR if remaining != 0, else FIN.
REQ-030 FIN: valid SHALL be high for exactly one cycle; busy SHALL then clear and the FSM SHALL return to IDLE.
REQ-031 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-032 awvalid, wvalid and valid SHALL never depend combinationally on awready or wready.
REQ-033 An error SHALL NOT abort the transfer; all bursts complete.
REQ-034 Latency: start in cycle N gives awvalid in cycle N+1, or valid in cycle N+1 when num_beats==0.
REQ-035 s_ready SHALL be 0 outside DATA, and no AXI valid or ready output SHALL be high outside its own state.

Reset
REQ-036 Under rst:
  - the state SHALL be IDLE;
  - busy, valid, error, awvalid, wvalid, wlast, bready and s_ready SHALL be 0;
  - the latched address, remaining count and beat counter SHALL be 0.
REQ-037 rst asserted mid-transfer SHALL abandon the transfer in the next cycle and SHALL NOT produce a valid pulse.

Structure
REQ-038 A shared package axi_wb_pkg SHALL hold:
  - the state enum;
  - AXI_BURST_INCR = 2'b01;
  - AXI_RESP_OKAY = 2'b00;
  - a function computing awsize from DATA_WIDTH.
REQ-039 One sub-module, axi_burst_split, SHALL compute beats, awlen and the next address and remaining count from remaining, address and MAX_BURST. It SHALL be purely combinational.

Verification
REQ-040 num_beats=5, MAX_BURST=16, always-ready slave, base 0x0100 -> one burst with awlen=4 and awaddr=0x0100; wlast on beat 5; valid 1 cycle after bvalid; error=0.
REQ-041 num_beats=40, MAX_BURST=16, DATA_WIDTH=32, base 0x0000 -> three bursts:
  - awlen 15/15/7;
  - awaddr 0x0000/0x0040/0x0080;
  - exactly 40 data beats in order.
REQ-042 num_beats=0 -> valid pulses in the cycle after start; no awvalid or wvalid ever asserted.
REQ-043 Random s_valid and wready stalls, num_beats=20 -> the data sequence on the bus equals the stream order; no beat is lost or duplicated; awvalid stays held until awready.
REQ-044 bresp=2'b10 on burst 1 of 2 -> the second burst still issues, error=1 at valid, and error clears on the next start.
REQ-045 rst asserted in DATA after 3 beats -> all outputs are 0 the next cycle, no valid pulse, and a new start works normally.

Source files
------------

// File: rtl/axi_stream_burst_writer_pkg.sv
// Shared types and constants for the AXI stream burst writer.
package axi_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_FIN
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // awsize encodes log2 of the bytes per beat
    function automatic logic [2:0] awsize_for(input int unsigned data_width);
        case (data_width)
            8:       return 3'd0;
            16:      return 3'd1;
            32:      return 3'd2;
            64:      return 3'd3;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/axi_stream_burst_writer_if.sv
// Input stream plus AXI write address/data/response channels.
interface axi_stream_burst_writer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_valid;
    logic                    s_ready;

    logic [ADDR_WIDTH-1:0]   axi_awaddr;
    logic [7:0]              axi_awlen;
    logic [2:0]              axi_awsize;
    logic [1:0]              axi_awburst;
    logic                    axi_awvalid;
    logic                    axi_awready;

    logic [DATA_WIDTH-1:0]   axi_wdata;
    logic [DATA_WIDTH/8-1:0] axi_wstrb;
    logic                    axi_wlast;
    logic                    axi_wvalid;
    logic                    axi_wready;

    logic [1:0]              axi_bresp;
    logic                    axi_bvalid;
    logic                    axi_bready;

    modport master (
        input  s_data, s_valid,
        output s_ready,
        output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready,
        input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready
    );

endinterface

// File: rtl/axi_stream_burst_writer_split.sv
// Combinational burst sizing: beats for the current burst and the
// address/remaining count once that burst completes.
module axi_burst_split #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic [LEN_WIDTH-1:0]  remaining,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [8:0]            beats,
    output logic [7:0]            awlen,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [LEN_WIDTH-1:0]  next_remaining
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [31:0] rem_w;
    logic [31:0] beats_w;

    always_comb begin
        rem_w          = 32'(remaining);
        beats_w        = (rem_w < 32'(MAX_BURST)) ? rem_w : 32'(MAX_BURST);
        beats          = beats_w[8:0];
        awlen          = 8'(beats_w - 32'd1);
        next_remaining = remaining - LEN_WIDTH'(beats_w);
        next_addr      = addr + ADDR_WIDTH'(beats_w * BYTES);
    end

endmodule

// File: rtl/axi_stream_burst_writer.sv
// Splits a stream of num_beats words into INCR bursts of up to MAX_BURST
// beats and writes them over AXI starting at base_addr.
module axi_stream_burst_writer
    import axi_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_beats,
    output logic                  busy,
    output logic                  valid,
    output logic                  error,
    axi_stream_burst_writer_if.master bus
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [7:0]            beat_cnt;

    logic [8:0]            beats;
    logic [7:0]            awlen;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  next_remaining;
    logic                  in_data;
    logic                  last_beat;
    logic                  beat_xfer;

    axi_burst_split #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_split (
        .remaining      (remaining),
        .addr           (addr),
        .beats          (beats),
        .awlen          (awlen),
        .next_addr      (next_addr),
        .next_remaining (next_remaining)
    );

    assign in_data   = (state == ST_DATA);
    assign last_beat = (({1'b0, beat_cnt} + 9'd1) == beats);
    assign beat_xfer = in_data && bus.s_valid && bus.axi_wready;

    assign busy  = (state != ST_IDLE);
    assign valid = (state == ST_FIN);

    // aw fields come straight from registers, so they hold while awvalid waits
    assign bus.axi_awvalid = (state == ST_ADDR);
    assign bus.axi_awaddr  = addr;
    assign bus.axi_awlen   = awlen;
    assign bus.axi_awsize  = awsize_for(DATA_WIDTH);
    assign bus.axi_awburst = AXI_BURST_INCR;

    assign bus.axi_wvalid  = in_data && bus.s_valid;
    assign bus.s_ready     = in_data && bus.axi_wready;
    assign bus.axi_wdata   = bus.s_data;
    assign bus.axi_wstrb   = '1;
    assign bus.axi_wlast   = in_data && last_beat;
    assign bus.axi_bready  = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= num_beats;
                        beat_cnt  <= '0;
                        error     <= 1'b0;
                        state     <= (num_beats == '0) ? ST_FIN : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.axi_awready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (beat_xfer) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= ST_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.axi_bvalid) begin
                        if (bus.axi_bresp != AXI_RESP_OKAY) error <= 1'b1;
                        remaining <= next_remaining;
                        addr      <= next_addr;
                        state     <= (next_remaining != '0) ? ST_ADDR : ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// Directed bench for axi_stream_burst_writer with a behavioural AXI slave and stream source.
module tb_axi_stream_burst_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] num_beats = '0;
    logic        busy, valid, error;

    axi_stream_burst_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axi_stream_burst_writer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .LEN_WIDTH  (16),
        .MAX_BURST  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_beats (num_beats),
        .busy      (busy),
        .valid     (valid),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] wd_q[$];
    bit          wl_q[$];

    int   cyc = 0, valid_cnt = 0, b_cyc = 0, v_cyc = 0;
    int   axi_seen = 0, hold_bad = 0, strb_bad = 0;
    bit   err_at_valid = 1'b0;
    bit   w_taken = 1'b0, wlast_taken = 1'b0, b_taken = 1'b0, aw_wait = 1'b0;
    logic [15:0] aw_wait_addr = '0;
    logic [7:0]  aw_wait_len = '0;

    // Mid-cycle monitor: values here are what the next posedge will see.
    always @(negedge clk) begin
        cyc++;
        w_taken     = bus.axi_wvalid && bus.axi_wready;
        wlast_taken = w_taken && bus.axi_wlast;
        b_taken     = bus.axi_bvalid && bus.axi_bready;
        if (aw_wait && (!bus.axi_awvalid || bus.axi_awaddr !== aw_wait_addr ||
                        bus.axi_awlen !== aw_wait_len))
            hold_bad++;
        aw_wait      = bus.axi_awvalid && !bus.axi_awready;
        aw_wait_addr = bus.axi_awaddr;
        aw_wait_len  = bus.axi_awlen;
        if (bus.axi_awvalid && bus.axi_awready) begin
            aw_addr_q.push_back(bus.axi_awaddr);
            aw_len_q.push_back(bus.axi_awlen);
        end
        if (w_taken) begin
            wd_q.push_back(bus.axi_wdata);
            wl_q.push_back(bus.axi_wlast);
            if (bus.axi_wstrb !== 4'hF) strb_bad++;
        end
        if (b_taken) b_cyc = cyc;
        if (valid) begin
            valid_cnt++;
            v_cyc        = cyc;
            err_at_valid = error;
        end
        if (bus.axi_awvalid || bus.axi_wvalid) axi_seen++;
    end

    int src = 0, b_idx = 0, err_burst = -1;
    bit stall = 1'b0;

    // Stream source and AXI slave, updated just after each posedge.
    initial begin
        bus.s_data      = '0;
        bus.s_valid     = 1'b0;
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_bresp   = 2'b00;
        bus.axi_bvalid  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (w_taken) src++;
            bus.s_valid     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data      = 32'hA000_0000 + 32'(src);
            bus.axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_taken) begin
                bus.axi_bvalid = 1'b0;
                b_idx++;
            end
            if (wlast_taken) begin
                bus.axi_bvalid = 1'b1;
                bus.axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] n);
        @(posedge clk);
        #1;
        base_addr = a;
        num_beats = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input int v0, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (valid_cnt > v0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: valid_cnt=%0d required>%0d", name, valid_cnt, v0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({busy, valid, error, bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast,
             bus.axi_bready, bus.s_ready} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {busy, valid, error, bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast,
                      bus.axi_bready, bus.s_ready});
        end
        total++;
        if (bus.axi_awaddr !== 16'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h required 0000", bus.axi_awaddr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int a0 = aw_addr_q.size();
        int w0 = wd_q.size();
        int v0 = valid_cnt;
        int s0;
        bit dok = 1'b1;
        stall = 1'b0;
        repeat (2) tick();
        s0 = src;
        do_start(16'h0100, 16'd5);
        tick();
        total++;
        if ({busy, bus.axi_awvalid, bus.axi_awaddr, bus.axi_awlen, bus.axi_awsize,
             bus.axi_awburst} !== {1'b1, 1'b1, 16'h0100, 8'd4, 3'd2, 2'b01}) begin
            bad++;
            $display("FAIL single_aw_fields: got %h required %h",
                     {busy, bus.axi_awvalid, bus.axi_awaddr, bus.axi_awlen, bus.axi_awsize,
                      bus.axi_awburst}, {1'b1, 1'b1, 16'h0100, 8'd4, 3'd2, 2'b01});
        end
        wait_valid(100, v0, "single");
        total++;
        if (aw_addr_q.size() != a0 + 1 || aw_addr_q[a0] !== 16'h0100 || aw_len_q[a0] !== 8'd4) begin
            bad++;
            $display("FAIL single_burst: count=%0d required 1 (addr 0100 len 4)",
                     aw_addr_q.size() - a0);
        end
        total++;
        if (wd_q.size() != w0 + 5) begin
            bad++;
            $display("FAIL single_beats: got %0d required 5", wd_q.size() - w0);
        end else begin
            for (int i = 0; i < 5; i++)
                if (wd_q[w0+i] !== 32'hA000_0000 + 32'(s0 + i) || wl_q[w0+i] !== (i == 4)) dok = 1'b0;
            if (!dok) begin
                bad++;
                $display("FAIL single_data: first=%h required %h", wd_q[w0], 32'hA000_0000 + 32'(s0));
            end
        end
        total++;
        if (v_cyc != b_cyc + 1) begin
            bad++;
            $display("FAIL single_valid_latency: got %0d required %0d", v_cyc - b_cyc, 1);
        end
        total++;
        if (err_at_valid !== 1'b0 || strb_bad != 0) begin
            bad++;
            $display("FAIL single_err_strb: err=%b strb_bad=%0d required 0/0", err_at_valid, strb_bad);
        end
        repeat (2) tick();
        total++;
        if (valid_cnt != v0 + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: pulses=%0d busy=%b required 1/0", valid_cnt - v0, busy);
        end
    endtask

    task automatic test_multi();
        logic [15:0] exp_addr[3] = '{16'h0000, 16'h0040, 16'h0080};
        logic [7:0]  exp_len[3]  = '{8'd15, 8'd15, 8'd7};
        int a0 = aw_addr_q.size();
        int w0 = wd_q.size();
        int v0 = valid_cnt;
        int s0 = src;
        bit ok = 1'b1;
        stall = 1'b0;
        do_start(16'h0000, 16'd40);
        wait_valid(400, v0, "multi");
        total++;
        if (aw_addr_q.size() != a0 + 3) begin
            bad++;
            $display("FAIL multi_burst_count: got %0d required 3", aw_addr_q.size() - a0);
        end else begin
            for (int i = 0; i < 3; i++)
                if (aw_addr_q[a0+i] !== exp_addr[i] || aw_len_q[a0+i] !== exp_len[i]) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL multi_aw: got %h/%h %h/%h %h/%h required 0000/0f 0040/0f 0080/07",
                         aw_addr_q[a0], aw_len_q[a0], aw_addr_q[a0+1], aw_len_q[a0+1],
                         aw_addr_q[a0+2], aw_len_q[a0+2]);
            end
        end
        total++;
        if (wd_q.size() != w0 + 40) begin
            bad++;
            $display("FAIL multi_beats: got %0d required 40", wd_q.size() - w0);
        end else begin
            ok = 1'b1;
            for (int i = 0; i < 40; i++)
                if (wd_q[w0+i] !== 32'hA000_0000 + 32'(s0 + i) ||
                    wl_q[w0+i] !== (i == 15 || i == 31 || i == 39)) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL multi_data_wlast: order or wlast placement wrong, first=%h required %h",
                         wd_q[w0], 32'hA000_0000 + 32'(s0));
            end
        end
    endtask

    task automatic test_zero();
        int v0  = valid_cnt;
        int ax0 = axi_seen;
        stall = 1'b0;
        do_start(16'h0300, 16'd0);
        tick();
        total++;
        if ({valid, busy, bus.axi_awvalid} !== 3'b110) begin
            bad++;
            $display("FAIL zero_valid_next_cycle: got %b required 110", {valid, busy, bus.axi_awvalid});
        end
        repeat (3) tick();
        total++;
        if (valid_cnt != v0 + 1 || axi_seen != ax0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_quiet: pulses=%0d axi_cycles=%0d busy=%b required 1/0/0",
                     valid_cnt - v0, axi_seen - ax0, busy);
        end
    endtask

    task automatic test_stall();
        int a0 = aw_addr_q.size();
        int w0 = wd_q.size();
        int v0 = valid_cnt;
        int h0 = hold_bad;
        int s0 = src;
        bit ok = 1'b1;
        stall = 1'b1;
        do_start(16'h0200, 16'd20);
        wait_valid(2000, v0, "stall");
        stall = 1'b0;
        total++;
        if (aw_addr_q.size() != a0 + 2 || aw_addr_q[a0] !== 16'h0200 || aw_len_q[a0] !== 8'd15 ||
            aw_addr_q[a0+1] !== 16'h0240 || aw_len_q[a0+1] !== 8'd3) begin
            bad++;
            $display("FAIL stall_aw: count=%0d required 2 (0200/0f 0240/03)", aw_addr_q.size() - a0);
        end
        total++;
        if (wd_q.size() != w0 + 20) begin
            bad++;
            $display("FAIL stall_beats: got %0d required 20", wd_q.size() - w0);
        end else begin
            for (int i = 0; i < 20; i++)
                if (wd_q[w0+i] !== 32'hA000_0000 + 32'(s0 + i) || wl_q[w0+i] !== (i == 15 || i == 19))
                    ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL stall_data: stream order or wlast wrong, first=%h required %h",
                         wd_q[w0], 32'hA000_0000 + 32'(s0));
            end
        end
        total++;
        if (hold_bad != h0) begin
            bad++;
            $display("FAIL stall_aw_hold: violations=%0d required 0", hold_bad - h0);
        end
    endtask

    task automatic test_error();
        int a0 = aw_addr_q.size();
        int v0 = valid_cnt;
        stall = 1'b0;
        err_burst = b_idx;
        do_start(16'h1000, 16'd20);
        wait_valid(400, v0, "error");
        total++;
        if (aw_addr_q.size() != a0 + 2 || aw_addr_q[a0+1] !== 16'h1040 || aw_len_q[a0+1] !== 8'd3) begin
            bad++;
            $display("FAIL error_second_burst: count=%0d required 2 (second 1040/03)", aw_addr_q.size() - a0);
        end
        total++;
        if (err_at_valid !== 1'b1) begin
            bad++;
            $display("FAIL error_at_valid: got %b required 1", err_at_valid);
        end
        repeat (2) tick();
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL error_sticky: got %b required 1", error);
        end
        err_burst = -1;
        v0 = valid_cnt;
        do_start(16'h2000, 16'd1);
        tick();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL error_cleared_on_start: got %b required 0", error);
        end
        wait_valid(100, v0, "error_next");
        total++;
        if (err_at_valid !== 1'b0) begin
            bad++;
            $display("FAIL error_next_transfer: got %b required 0", err_at_valid);
        end
    endtask

    task automatic test_rst_mid();
        int w0 = wd_q.size();
        int v0 = valid_cnt;
        int a0, s0;
        bit seen = 1'b0;
        bit ok = 1'b1;
        stall = 1'b0;
        do_start(16'h0000, 16'd10);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wd_q.size() >= w0 + 3) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_beats_timeout: got %0d required 3", wd_q.size() - w0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, valid, error, bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast,
             bus.axi_bready, bus.s_ready} !== 8'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %b required 00000000",
                     {busy, valid, error, bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast,
                      bus.axi_bready, bus.s_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (valid_cnt != v0) begin
            bad++;
            $display("FAIL rst_mid_no_valid: pulses=%0d required 0", valid_cnt - v0);
        end
        a0 = aw_addr_q.size();
        w0 = wd_q.size();
        s0 = src;
        do_start(16'h0400, 16'd3);
        wait_valid(100, v0, "rst_restart");
        total++;
        if (aw_addr_q.size() != a0 + 1 || aw_addr_q[a0] !== 16'h0400 || aw_len_q[a0] !== 8'd2) begin
            bad++;
            $display("FAIL rst_restart_aw: count=%0d required 1 (0400/02)", aw_addr_q.size() - a0);
        end
        total++;
        if (wd_q.size() != w0 + 3) begin
            bad++;
            $display("FAIL rst_restart_beats: got %0d required 3", wd_q.size() - w0);
        end else begin
            for (int i = 0; i < 3; i++)
                if (wd_q[w0+i] !== 32'hA000_0000 + 32'(s0 + i) || wl_q[w0+i] !== (i == 2)) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rst_restart_data: first=%h required %h", wd_q[w0], 32'hA000_0000 + 32'(s0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_stall();
        test_error();
        test_rst_mid();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
